imc_remem_unit: RTL
===================

# imc_remem_unit

Parametrised in-memory-compute memristor array with integrated controller. Replaces the split controller/array pair with one block behind a command/response handshake. Executes row read, row write and bitwise row-pair gates (OR/NOR/AND/NAND/XOR/XNOR), with optional write-back of the gate result to a destination row. Sits behind the pipeline's memory stage; `cmd_ready` low is the pipeline stall.

## Interface
- `WIDTH`, 32: bits per row.
- `ROWS`, 32: number of rows; need not be a power of two.
- `ADDR_W`, 5: row address width; must satisfy 2^ADDR_W >= ROWS.
- `CLEAR_ON_RESET`, 1: 1 = all rows zeroed on reset; 0 = array contents retained across reset.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block accepts a command this cycle.
- `cmd_op` in 5: [3:0] operation; [4] write-back flag (gate ops only).
- `cmd_rs1` in ADDR_W: source row 1 (read/gate).
- `cmd_rs2` in ADDR_W: source row 2 (gate).
- `cmd_rd` in ADDR_W: destination row (write, gate write-back).
- `cmd_wdata` in WIDTH: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out WIDTH: read/gate result, or written value for WRITE.
- `rsp_err` out 1: qualifies `rsp_valid`; illegal op or address.
- `busy` out 1: write-back in progress.

## Operation
- Op codes, `cmd_op[3:0]`: 0 NOP, 1 READ, 2 WRITE, 3 OR, 4 NOR, 5 AND, 6 NAND, 7 XOR, 8 XNOR, 9–15 illegal.
- **Accept:** a command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- **NOP:** accepted, produces no response.
- **READ:** result = mem[rs1].
- **Gates:** result = mem[rs1] op mem[rs2]; the N-variants are the bitwise inverse.
  - rs1 == rs2 is legal and uses the same row for both operands, e.g. XOR gives 0 and OR gives mem[rs1].
- **WRITE:** mem[rd] <= wdata at the accept edge; response data = wdata.
- **Write-back flag:**
  - `cmd_op[4]=1` on a gate op stores the result into mem[rd] one cycle after accept.
  - `cmd_op[4]=1` on READ or WRITE is illegal.
- **Error conditions:** an illegal op, or any used address >= ROWS, gives: no array change, `rsp_err=1`, `rsp_data=0`.
- **FSM states:**
  - IDLE: `cmd_ready=1`.
  - IDLE -> WB on accepting a gate with write-back.
  - WB: `cmd_ready=0`, `busy=1`; writes the registered result to mem[rd].
  - WB -> IDLE unconditionally.
- **Read-after-write:** the array is read combinationally at accept, so a command accepted the cycle after WRITE or WB sees the new data.
  - rd == rs1 in a write-back gate uses the pre-write operands; the registered result is then written.
- **Reset outputs:** `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`, state IDLE.
  - `cmd_ready=0` while `rst` is high and 1 in the first cycle after.
  - With CLEAR_ON_RESET=1 all rows are 0; otherwise rows are unchanged.
- **Reset during WB:** the pending write-back is aborted. mem[rd] is not written unless cleared by CLEAR_ON_RESET.

## Timing
- **Response latency:** exactly 1 cycle for every non-NOP op, error responses included. `rsp_valid`, `rsp_data` and `rsp_err` are registered and valid in the cycle after the accept edge.
- **Non-write-back throughput:** 1 command/cycle; back-to-back READ/WRITE/gate responses pulse on consecutive cycles.
- **Write-back throughput:** 2 cycles/command.
  - The response is presented during the WB cycle.
  - The array update lands at the end of the WB cycle.
  - The next command is accepted no earlier than 2 edges after the write-back accept.
- **Hold when not ready:** `cmd_valid` held while `cmd_ready=0` is neither accepted nor lost. Command fields may change freely until acceptance.
- **Outside a response:** when `rsp_valid=0`, `rsp_data` and `rsp_err` are 0.

## Test plan
- **Reset and basic write/read:** reset, then WRITE rd=3 data 0xA5A5_0F0F; READ rs1=3 next cycle -> `rsp_valid` one cycle later with 0xA5A5_0F0F, `rsp_err=0`.
- **Gate truth:** rows 1=0xF0F0_F0F0 and 2=0xFF00_FF00.
  - OR -> 0xFFF0_FFF0; NOR -> 0x000F_000F.
  - AND -> 0xF000_F000; NAND -> 0x0FFF_0FFF.
  - XOR -> 0x0FF0_0FF0; XNOR -> 0xF00F_F00F.
  - rs1=rs2=1: XOR -> 0.
- **Write-back stall:** XOR|WB rs1=1, rs2=2, rd=1 with `cmd_valid` held high.
  - `cmd_ready=0` and `busy=1` for exactly 1 cycle; the response in that cycle is 0x0FF0_0FF0.
  - The following READ rs1=1 returns 0x0FF0_0FF0.
- **Errors:** op=12 -> `rsp_err=1`, `rsp_data=0`, no row changes. READ rs1=ROWS with ROWS=20 and ADDR_W=5 -> `rsp_err=1`. WRITE with `cmd_op[4]=1` -> `rsp_err=1`.
- **Reset mid-WB:**
  - CLEAR_ON_RESET=0: assert `rst` in the WB cycle; mem[rd] keeps its old value, `busy=0` and `rsp_valid=0` next cycle.
  - CLEAR_ON_RESET=1: all reads return 0 after reset.
- **Back-to-back:** WRITE r5=1, READ r5, OR r5|r5, NOP on consecutive cycles -> responses 1, 1, 1 on consecutive cycles, then none.

Source files
------------

// File: rtl/imc_remem_unit_if.sv
// Command/response handshake for the in-memory-compute memristor array.
// The pipeline side drives commands through master; the array block is the slave.
interface imc_remem_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;
  logic [WIDTH-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/imc_remem_unit.sv
// Memristor row array with integrated controller: row read/write, bitwise row-pair
// gates and optional write-back of the gate result, behind a valid/ready handshake.
module imc_remem_unit #(
  parameter int WIDTH          = 32,
  parameter int ROWS           = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            rst,
  imc_remem_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    WB
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_NAND  = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_XNOR  = 4'd8;

  // One extra bit so ROWS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] ROWS_LIM = (ADDR_W + 1)'(ROWS);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  mem [ROWS];

  logic              ready;
  logic              busy_int;
  logic              accept;
  logic [3:0]        op;
  logic              wb_flag;
  logic              is_gate;
  logic              op_legal;
  logic              use_rs1;
  logic              use_rs2;
  logic              use_rd;
  logic              rs1_ok;
  logic              rs2_ok;
  logic              rd_ok;
  logic              cmd_err;
  logic              has_rsp;
  logic              do_write;
  logic              do_wb;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  result;

  logic [ADDR_W-1:0] wb_row;
  logic [WIDTH-1:0]  wb_data;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WIDTH-1:0]  rsp_data_q;

  always_comb begin
    op       = bus.cmd_op[3:0];
    wb_flag  = bus.cmd_op[4];
    is_gate  = (op >= OP_OR) && (op <= OP_XNOR);
    op_legal = (op <= OP_XNOR) && !(wb_flag && ((op == OP_READ) || (op == OP_WRITE)));
    use_rs1  = (op == OP_READ) || is_gate;
    use_rs2  = is_gate;
    use_rd   = (op == OP_WRITE) || (is_gate && wb_flag);
    rs1_ok   = ({1'b0, bus.cmd_rs1} < ROWS_LIM);
    rs2_ok   = ({1'b0, bus.cmd_rs2} < ROWS_LIM);
    rd_ok    = ({1'b0, bus.cmd_rd} < ROWS_LIM);
    cmd_err  = !op_legal || (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok) || (use_rd && !rd_ok);
    has_rsp  = (op != OP_NOP);
    // Operand rows are read combinationally so a write landing on the previous edge is visible.
    opa      = rs1_ok ? mem[bus.cmd_rs1] : '0;
    opb      = rs2_ok ? mem[bus.cmd_rs2] : '0;
    case (op)
      OP_READ:  result = opa;
      OP_WRITE: result = bus.cmd_wdata;
      OP_OR:    result = opa | opb;
      OP_NOR:   result = ~(opa | opb);
      OP_AND:   result = opa & opb;
      OP_NAND:  result = ~(opa & opb);
      OP_XOR:   result = opa ^ opb;
      OP_XNOR:  result = ~(opa ^ opb);
      default:  result = '0;
    endcase
  end

  assign accept   = bus.cmd_valid && ready;
  assign do_write = accept && (op == OP_WRITE) && !cmd_err;
  assign do_wb    = accept && is_gate && wb_flag && !cmd_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_wb) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == IDLE) && !rst;
    busy_int = (state == WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= accept && has_rsp;
      rsp_err_q   <= accept && has_rsp && cmd_err;
      rsp_data_q  <= (accept && has_rsp && !cmd_err) ? result : '0;
    end
  end

  // The gate result is captured from pre-write operands, so rd == rs1 is safe.
  always_ff @(posedge clk) begin
    if (do_wb) begin
      wb_row  <= bus.cmd_rd;
      wb_data <= result;
    end
  end

  // A reset during WB drops the pending write-back; clearing is the only reset-time update.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[bus.cmd_rd] <= bus.cmd_wdata;
    end else if (state == WB) begin
      mem[wb_row] <= wb_data;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = busy_int;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
